dma_mem_responder: RTL

- Memory-side end of the disk DMA interface: answers dmaREQ from the SD/RK8E disk controller with dmaGNT.
- Services per-word dmaRD/dmaWR strobes against PDP-8 main memory.
- Stalls the CPU at a memory-cycle boundary while the disk owns the bus.
- Sits between the disk controller and the memory array, alongside the CPU memory port.

---
 rtl/dma_mem_responder_if.sv | 22 ++
 rtl/dma_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder_if.sv
// Disk-side DMA port between the SD/RK8E disk controller (master) and the memory responder (slave).
interface dma_mem_responder_if #(
    parameter int AW = 15
);
    logic          dmaREQ;
    logic          dmaRD;
    logic          dmaWR;
    logic [AW-1:0] dmaADDR;
    logic [11:0]   dmaDOUT;
    logic [11:0]   dmaDIN;
    logic          dmaGNT;

    modport master (
        output dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT,
        input  dmaDIN, dmaGNT
    );

    modport slave (
        input  dmaREQ, dmaRD, dmaWR, dmaADDR, dmaDOUT,
        output dmaDIN, dmaGNT
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Memory-side responder for the disk DMA port: grants the bus, stalls the CPU and runs
// single-word reads/writes. Define DMA_WATCHDOG_EN to add the idle-grant watchdog.
module dma_mem_responder #(
    parameter int TIMEOUT = 4096,
    parameter int AW      = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    dma_mem_responder_if.slave dma,
    input  logic               cpu_idle,
    output logic               cpu_hold,
    output logic [AW-1:0]      mem_addr,
    output logic [11:0]        mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    input  logic [11:0]        mem_rdata,
    output logic [15:0]        dma_words,
    output logic               dma_timeout
);
    typedef enum logic [2:0] {IDLE, WAITCPU, GRANT, RDWAIT, RELEASE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          gnt_q;
    logic          gnt_nx;
    logic          hold_nx;
    logic          we_nx;
    logic          re_nx;
    logic          din_load;
    logic          word_done;
    logic [AW-1:0] addr_nx;
    logic [11:0]   wdata_nx;
    logic [11:0]   din_q;
    logic          strobe_take;
    logic          wd_fire;
    logic          regrant_block;

    assign dma.dmaGNT = gnt_q;
    assign dma.dmaDIN = din_q;

    // The first GRANT cycle still shows dmaGNT=0, so strobes there are not taken.
    assign strobe_take = (state == GRANT) && gnt_q && (dma.dmaRD || dma.dmaWR);

    always_comb begin
        state_nx  = state;
        we_nx     = 1'b0;
        re_nx     = 1'b0;
        din_load  = 1'b0;
        word_done = 1'b0;
        addr_nx   = mem_addr;
        wdata_nx  = mem_wdata;

        case (state)
            IDLE: begin
                if (dma.dmaREQ && !regrant_block) begin
                    state_nx = cpu_idle ? GRANT : WAITCPU;
                end
            end
            WAITCPU: begin
                if (!dma.dmaREQ) begin
                    state_nx = IDLE;
                end else if (cpu_idle) begin
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (strobe_take && dma.dmaWR) begin
                    we_nx     = 1'b1;
                    addr_nx   = dma.dmaADDR;
                    wdata_nx  = dma.dmaDOUT;
                    word_done = 1'b1;
                    if (!dma.dmaREQ) begin
                        state_nx = RELEASE;
                    end
                end else if (strobe_take) begin
                    re_nx    = 1'b1;
                    addr_nx  = dma.dmaADDR;
                    state_nx = RDWAIT;
                end else if (!dma.dmaREQ || wd_fire) begin
                    state_nx = RELEASE;
                end
            end
            RDWAIT: begin
                // First RDWAIT cycle carries mem_re; memory data is there on the second.
                if (!mem_re) begin
                    din_load  = 1'b1;
                    word_done = 1'b1;
                    state_nx  = dma.dmaREQ ? GRANT : RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        hold_nx = (state_nx == GRANT) || (state_nx == RDWAIT);
        gnt_nx  = hold_nx && ((state == GRANT) || (state == RDWAIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt_q     <= 1'b0;
            cpu_hold  <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 12'd0;
            din_q     <= 12'd0;
            dma_words <= 16'd0;
        end else if (clear) begin
            state     <= IDLE;
            gnt_q     <= 1'b0;
            cpu_hold  <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 12'd0;
            din_q     <= 12'd0;
            dma_words <= 16'd0;
        end else begin
            state     <= state_nx;
            gnt_q     <= gnt_nx;
            cpu_hold  <= hold_nx;
            mem_we    <= we_nx;
            mem_re    <= re_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            if (din_load) begin
                din_q <= mem_rdata;
            end
            if (word_done) begin
                dma_words <= dma_words + 16'd1;
            end
        end
    end

`ifdef DMA_WATCHDOG_EN
    localparam logic [12:0] WD_LAST = 13'(TIMEOUT - 1);

    logic [12:0] wd_cnt;
    logic        timeout_q;

    assign wd_fire     = (state == GRANT) && !strobe_take && (wd_cnt == WD_LAST);
    assign dma_timeout = timeout_q;

    // After a timeout the disk must drop dmaREQ before it can be granted again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt        <= 13'd0;
            timeout_q     <= 1'b0;
            regrant_block <= 1'b0;
        end else if (clear) begin
            wd_cnt        <= 13'd0;
            timeout_q     <= 1'b0;
            regrant_block <= 1'b0;
        end else begin
            wd_cnt <= ((state == GRANT) && !strobe_take && !wd_fire) ? wd_cnt + 13'd1 : 13'd0;
            if (wd_fire) begin
                timeout_q     <= 1'b1;
                regrant_block <= 1'b1;
            end else if (!dma.dmaREQ) begin
                regrant_block <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    // Without the watchdog a grant is held for as long as dmaREQ stays high.
    assign unused_timeout = (TIMEOUT != 0);
    assign wd_fire        = 1'b0;
    assign regrant_block  = 1'b0;
    assign dma_timeout    = 1'b0;
`endif

endmodule
